alib_rank_symbol_decoder: RTL and testbench
===========================================

Name: alib_rank_symbol_decoder

Overview:
- Inverse of the ranked frequency table: maps ranks back to 8-bit symbols, for the decompression side of rank-based coding.
- Build phase: the block reads the char->rank query interface of a ranked frequency table for all 256 chars and fills an internal rank->char table.
- Decode phase: NUMBER_PARALLEL_INPUTS lanes of ranks are translated to symbols each cycle.

Parameters:
- NUMBER_PARALLEL_INPUTS, 8, decode lanes per cycle (1..16).
- QUERY_LATENCY, 1, cycles from o_query_char to a valid i_query_rank (1..4).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_start_build  in  1  pulse; starts a table build.
- o_build_busy  out  1  high while a build is in progress.
- o_build_done  out  1  one-cycle pulse when the build completes.
- o_table_ready  out  1  level; table is valid for decoding.
- o_query_char  out  8  char presented to the frequency-table query port.
- i_query_rank  in  8  rank returned for the char issued QUERY_LATENCY cycles earlier.
- i_rank  in  8*N  concatenated lane ranks; lane k is [8k+7:8k].
- i_valid  in  N  per-lane valid.
- o_char  out  8*N  decoded symbols.
- o_valid  out  N  per-lane output valid.
- o_table_error  out  1  sticky duplicate-rank flag (see Optional Feature).

Behaviour:
- Reset values: state IDLE; o_build_busy=0, o_build_done=0, o_table_ready=0, o_query_char=0, o_char=0, o_valid=0, o_table_error=0.
- Table RAM (256x8) has no reset. Its contents are gated by o_table_ready.
- FSM states:
  - IDLE: wait for i_start_build.
  - ISSUE: o_query_char steps 0..255, one char per cycle.
  - DRAIN: wait QUERY_LATENCY cycles for the last responses.
  - READY: table valid for decoding.
- Transitions:
  - IDLE or READY with i_start_build=1 -> ISSUE on the next edge; o_table_ready clears on the same edge.
  - ISSUE exits to DRAIN after char 255 is issued.
  - DRAIN exits to READY after QUERY_LATENCY cycles. o_build_done pulses for 1 cycle on entry to READY; o_table_ready rises on the same edge.
- Build capture: the issued char is delayed QUERY_LATENCY stages in a shift register. When a delayed char is valid, write table[i_query_rank] = delayed_char.
- Build duration: i_start_build to o_build_done = 256 + QUERY_LATENCY + 1 cycles.
- o_build_busy is high in ISSUE and DRAIN. i_start_build is ignored while busy.
- Decode:
  - Registered, latency 1.
  - o_valid[k] = i_valid[k] & o_table_ready, sampled at the edge.
  - o_char lane k = table[i_rank lane k] when its o_valid bit is set, else 0x00.
  - Decode inputs arriving during a build produce o_valid=0.
- Reset mid-build: return to IDLE, o_table_ready=0, and discard the partial table. A fresh build is required.
- Non-bijective responder: the last write to a rank wins. Ranks never written keep stale contents; this is not detected unless the feature below is enabled.

Optional Feature:
- Macro: ALIB_RANK_SYMBOL_DECODER_DUP_CHECK_EN.
- Enabled:
  - A 256-bit "seen" bitmap is cleared at build start.
  - A capture to an already-seen rank sets o_table_error on the next edge.
  - o_table_error stays set until the next i_start_build or reset.
  - At build end, any unseen rank also sets o_table_error, in the same cycle as o_build_done.
- Disabled: no bitmap is implemented and o_table_error is tied to 0.

Decomposition:
- Package alib_rank_pkg holds:
  - SYMBOL_BITS=8, NUM_SYMBOLS=256.
  - FSM state enum (IDLE, ISSUE, DRAIN, READY).
  - Lane-slice helper function.
- Sub-module alib_rank_symbol_ram: 256x8 storage with 1 write port and N asynchronous read ports, instantiated once. Top level holds the FSM, delay line, duplicate check and output registers.

Test Plan:
- Build with responder rank = 255 - char, QUERY_LATENCY=1 -> o_build_done exactly 258 cycles after i_start_build; o_table_ready=1; o_table_error=0.
- After that build, i_rank lanes {0x00, 0xBE, 0xFF, 0x7F, ...} with i_valid=8'hFF -> next cycle o_char lanes {0xFF, 0x41, 0x00, 0x80, ...}, o_valid=8'hFF.
- Lane masking: i_valid=8'b01010101 -> o_valid=8'b01010101, and masked lanes of o_char are 0x00.
- Decode issued during a rebuild (i_valid=8'hFF) -> o_valid=0 throughout; i_start_build pulsed again mid-build is ignored and done timing is unchanged.
- With DUP_CHECK_EN: responder returns rank 5 for both chars 3 and 7 -> o_table_error=1 one cycle after char 7 is captured; it stays high through done and clears on the next i_start_build.
- Assert i_rst at cycle 100 of a build -> all outputs 0 asynchronously; a following build with the identity responder decodes rank 0x41 -> 0x41.

Source files
------------

// File: rtl/alib_rank_pkg.sv
// Shared definitions for the rank->symbol decoder.
// Contents: symbol/table sizing, build FSM state enum and a lane-slice helper
// used to pick one 8-bit lane out of a concatenated lane bus.
package alib_rank_pkg;

  localparam int unsigned SYMBOL_BITS = 8;
  localparam int unsigned NUM_SYMBOLS = 256;
  localparam int unsigned MAX_LANES   = 16;
  localparam int unsigned LANE_BUS_W  = SYMBOL_BITS * MAX_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } rank_state_e;

  // Extract lane 'lane' from a bus zero-extended to the maximum lane count.
  function automatic logic [SYMBOL_BITS-1:0] lane_slice(input logic [LANE_BUS_W-1:0] bus,
                                                        input int unsigned lane);
    lane_slice = SYMBOL_BITS'(bus >> (SYMBOL_BITS * lane));
  endfunction

endpackage

// File: rtl/alib_rank_symbol_ram.sv
// 256x8 rank->symbol storage: one synchronous write port, NUM_READ
// asynchronous read ports. Contents are not reset.
// Ports:
//   i_clk      clock
//   i_we       write enable
//   i_waddr    write address (rank)
//   i_wdata    write data (symbol)
//   i_raddr    concatenated read addresses, lane k at [8k+7:8k]
//   o_rdata_c  concatenated combinational read data
module alib_rank_symbol_ram
  import alib_rank_pkg::*;
#(
  parameter int unsigned NUM_READ = 8
) (
  input  logic                            i_clk,
  input  logic                            i_we,
  input  logic [SYMBOL_BITS-1:0]          i_waddr,
  input  logic [SYMBOL_BITS-1:0]          i_wdata,
  input  logic [SYMBOL_BITS*NUM_READ-1:0] i_raddr,
  output logic [SYMBOL_BITS*NUM_READ-1:0] o_rdata_c
);

  logic [SYMBOL_BITS-1:0] mem [NUM_SYMBOLS];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read ports, one per lane.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    assign o_rdata_c[SYMBOL_BITS*k +: SYMBOL_BITS] = mem[i_raddr[SYMBOL_BITS*k +: SYMBOL_BITS]];
  end

endmodule

// File: rtl/alib_rank_symbol_decoder.sv
// Rank -> symbol decoder. Builds an inverse table by querying a ranked
// frequency table for every char (build phase), then translates
// NUMBER_PARALLEL_INPUTS lanes of ranks to symbols per cycle (decode phase).
// Optional feature macro: ALIB_RANK_SYMBOL_DECODER_DUP_CHECK_EN (duplicate /
// missing rank detection on o_table_error; tied to 0 when undefined).
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_start_build      pulse: start a table build (ignored while busy)
//   o_build_busy       build in progress
//   o_build_done       one-cycle pulse when the table becomes valid
//   o_table_ready      table valid for decoding
//   o_query_char       char presented to the frequency-table query port
//   i_query_rank       rank for the char issued QUERY_LATENCY cycles earlier
//   i_rank / i_valid   decode lanes in (lane k at [8k+7:8k])
//   o_char / o_valid   decoded lanes out, one cycle later
//   o_table_error      sticky duplicate/missing rank flag
module alib_rank_symbol_decoder
  import alib_rank_pkg::*;
#(
  parameter int unsigned NUMBER_PARALLEL_INPUTS = 8,
  parameter int unsigned QUERY_LATENCY          = 1
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_start_build,
  output logic                                          o_build_busy,
  output logic                                          o_build_done,
  output logic                                          o_table_ready,
  output logic [SYMBOL_BITS-1:0]                        o_query_char,
  input  logic [SYMBOL_BITS-1:0]                        i_query_rank,
  input  logic [SYMBOL_BITS*NUMBER_PARALLEL_INPUTS-1:0] i_rank,
  input  logic [NUMBER_PARALLEL_INPUTS-1:0]             i_valid,
  output logic [SYMBOL_BITS*NUMBER_PARALLEL_INPUTS-1:0] o_char,
  output logic [NUMBER_PARALLEL_INPUTS-1:0]             o_valid,
  output logic                                          o_table_error
);

  localparam int unsigned LANES = NUMBER_PARALLEL_INPUTS;
  localparam int unsigned BUS_W = SYMBOL_BITS * LANES;
  localparam int unsigned CNT_W = 3;

  rank_state_e state, state_nxt;
  logic        start_accept;
  logic        build_end;
  logic [CNT_W-1:0] drain_cnt;

  logic [QUERY_LATENCY-1:0] dly_vld;
  logic [SYMBOL_BITS-1:0]   dly_char [QUERY_LATENCY];
  logic                     cap_we;
  logic [BUS_W-1:0]         ram_rdata_c;

  // Next-state logic. DRAIN holds one cycle beyond QUERY_LATENCY so the last
  // capture has landed in the RAM (and the seen map) before READY.
  always_comb begin
    state_nxt    = state;
    start_accept = 1'b0;
    build_end    = 1'b0;
    case (state)
      IDLE, READY: begin
        if (i_start_build) begin
          state_nxt    = ISSUE;
          start_accept = 1'b1;
        end
      end
      ISSUE: begin
        if (o_query_char == SYMBOL_BITS'(NUM_SYMBOLS - 1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(QUERY_LATENCY)) begin
          state_nxt = READY;
          build_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Build control, query issue counter and query delay line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_build_busy  <= 1'b0;
      o_build_done  <= 1'b0;
      o_table_ready <= 1'b0;
      o_query_char  <= '0;
      drain_cnt     <= '0;
      dly_vld       <= '0;
      for (int i = 0; i < QUERY_LATENCY; i++) begin
        dly_char[i] <= '0;
      end
    end else begin
      o_build_busy  <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      o_build_done  <= build_end;
      o_table_ready <= (state_nxt == READY);
      if (start_accept) begin
        o_query_char <= '0;
      end else if ((state == ISSUE) && (state_nxt == ISSUE)) begin
        o_query_char <= o_query_char + SYMBOL_BITS'(1);
      end
      drain_cnt   <= (state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;
      dly_vld[0]  <= (state == ISSUE);
      dly_char[0] <= o_query_char;
      for (int i = 1; i < QUERY_LATENCY; i++) begin
        dly_vld[i]  <= dly_vld[i-1];
        dly_char[i] <= dly_char[i-1];
      end
    end
  end

  assign cap_we = dly_vld[QUERY_LATENCY-1];

  alib_rank_symbol_ram #(
    .NUM_READ (LANES)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (cap_we),
    .i_waddr   (i_query_rank),
    .i_wdata   (dly_char[QUERY_LATENCY-1]),
    .i_raddr   (i_rank),
    .o_rdata_c (ram_rdata_c)
  );

  // Decode output registers; lanes are masked by the table-ready level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= '0;
      o_char  <= '0;
    end else begin
      o_valid <= i_valid & {LANES{o_table_ready}};
      for (int k = 0; k < LANES; k++) begin
        o_char[SYMBOL_BITS*k +: SYMBOL_BITS] <= (i_valid[k] && o_table_ready)
            ? lane_slice(LANE_BUS_W'(ram_rdata_c), k) : '0;
      end
    end
  end

`ifdef ALIB_RANK_SYMBOL_DECODER_DUP_CHECK_EN
  logic [NUM_SYMBOLS-1:0] seen;

  // Flag repeated ranks at capture and unwritten ranks at build end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seen          <= '0;
      o_table_error <= 1'b0;
    end else if (start_accept) begin
      seen          <= '0;
      o_table_error <= 1'b0;
    end else begin
      if (cap_we) begin
        seen[i_query_rank] <= 1'b1;
        if (seen[i_query_rank]) begin
          o_table_error <= 1'b1;
        end
      end
      if (build_end && !(&seen)) begin
        o_table_error <= 1'b1;
      end
    end
  end
`else
  assign o_table_error = 1'b0;
`endif

endmodule

// File: tb/tb_alib_rank_symbol_decoder.sv
module tb_alib_rank_symbol_decoder;

  localparam int unsigned N = 8;
  localparam int unsigned L = 1;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_start_build;
  logic           o_build_busy;
  logic           o_build_done;
  logic           o_table_ready;
  logic [7:0]     o_query_char;
  logic [7:0]     i_query_rank;
  logic [8*N-1:0] i_rank;
  logic [N-1:0]   i_valid;
  logic [8*N-1:0] o_char;
  logic [N-1:0]   o_valid;
  logic           o_table_error;

  alib_rank_symbol_decoder #(
    .NUMBER_PARALLEL_INPUTS (N),
    .QUERY_LATENCY          (L)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start_build (i_start_build),
    .o_build_busy  (o_build_busy),
    .o_build_done  (o_build_done),
    .o_table_ready (o_table_ready),
    .o_query_char  (o_query_char),
    .i_query_rank  (i_query_rank),
    .i_rank        (i_rank),
    .i_valid       (i_valid),
    .o_char        (o_char),
    .o_valid       (o_valid),
    .o_table_error (o_table_error)
  );

  always #5 i_clk = ~i_clk;

  // Frequency-table responder: 0 = 255-c, 1 = identity, 2 = 255-c with chars 3 and 7 -> rank 5.
  int resp_mode = 0;
  logic [7:0] resp_pipe [L];

  function automatic logic [7:0] resp_f(input logic [7:0] c, input int mode);
    case (mode)
      1:       resp_f = c;
      2:       resp_f = ((c == 8'd3) || (c == 8'd7)) ? 8'd5 : 8'd255 - c;
      default: resp_f = 8'd255 - c;
    endcase
  endfunction

  always @(posedge i_clk) begin
    resp_pipe[0] <= resp_f(o_query_char, resp_mode);
    for (int i = 1; i < L; i++) resp_pipe[i] <= resp_pipe[i-1];
  end
  assign i_query_rank = resp_pipe[L-1];

  // Scoreboard.
  typedef struct packed {
    logic [8*N-1:0] ch;
    logic [N-1:0]   v;
  } exp_t;
  exp_t sb_q[$];
  logic dec_issue = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare the registered decode output one cycle after each issue.
  initial begin
    logic p;
    exp_t e;
    forever begin
      @(posedge i_clk);
      p = dec_issue;
      @(negedge i_clk);
      if (p) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("dec_valid", 64'(o_valid), 64'(e.v));
          chk("dec_char", 64'(o_char), 64'(e.ch));
        end
      end
    end
  end

  // One decode cycle with its expected response.
  task automatic dec(input logic [63:0] r, input logic [7:0] v,
                     input logic [63:0] ech, input logic [7:0] ev);
    exp_t e;
    @(negedge i_clk);
    i_rank    = r;
    i_valid   = v;
    dec_issue = 1'b1;
    e.ch = ech;
    e.v  = ev;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    dec_issue = 1'b0;
    i_valid   = '0;
  endtask

  localparam logic [63:0] R1   = {8'hC3, 8'h80, 8'h10, 8'h01, 8'h7F, 8'hFF, 8'hBE, 8'h00};
  localparam logic [63:0] E1   = {8'h3C, 8'h7F, 8'hEF, 8'hFE, 8'h80, 8'h00, 8'h41, 8'hFF};
  localparam logic [63:0] E1M  = {8'h00, 8'h7F, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'hFF};
  localparam logic [63:0] RID  = {8'h55, 8'hAA, 8'h02, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h41};

  // Run a build; returns cycles from the start-sampling edge to the done pulse (-1 on timeout/reset).
  task automatic do_build(input int mode, input bit disturb, input int rst_at, output int lat);
    int n;
    exp_t e;
    resp_mode = mode;
    lat = -1;
    @(negedge i_clk);
    i_start_build = 1'b1;
    @(posedge i_clk);
    #1;
    i_start_build = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge i_clk);
      #1;
      n++;
      if (n == rst_at) begin
        i_rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            64'({o_build_busy, o_build_done, o_table_ready, o_query_char, o_valid, o_table_error}), 64'd0);
        chk("async_reset_char", 64'(o_char), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        break;
      end
      if (o_build_done) begin
        lat = n;
        break;
      end
      if (n == 1) begin
        chk("busy_during_build", 64'(o_build_busy), 64'd1);
        chk("ready_low_during_build", 64'(o_table_ready), 64'd0);
        chk("error_clear_on_start", 64'(o_table_error), 64'd0);
      end
`ifdef ALIB_RANK_SYMBOL_DECODER_DUP_CHECK_EN
      if (mode == 2 && n == 8) chk("dup_err_before", 64'(o_table_error), 64'd0);
      if (mode == 2 && n == 9) chk("dup_err_after", 64'(o_table_error), 64'd1);
`endif
      i_start_build = disturb && (n == 50);
      if (disturb) begin
        i_rank    = R1;
        i_valid   = '1;
        dec_issue = 1'b1;
        e.ch = '0;
        e.v  = '0;
        sb_q.push_back(e);
      end
    end
    i_start_build = 1'b0;
    dec_issue     = 1'b0;
    i_valid       = '0;
  endtask

  initial begin
    int lat;
    i_rst         = 1'b1;
    i_start_build = 1'b0;
    i_rank        = '0;
    i_valid       = '0;
    #12;
    chk("reset_outputs",
        64'({o_build_busy, o_build_done, o_table_ready, o_query_char, o_valid, o_table_error}), 64'd0);
    chk("reset_char", 64'(o_char), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // No table yet: decodes are masked.
    dec(R1, 8'hFF, 64'd0, 8'h00);

    // Build with rank = 255 - char.
    do_build(0, 1'b0, 0, lat);
    chk("build1_latency", 64'(lat), 64'd258);
    chk("build1_ready", 64'(o_table_ready), 64'd1);
    chk("build1_busy", 64'(o_build_busy), 64'd0);
    chk("build1_error", 64'(o_table_error), 64'd0);
    @(posedge i_clk);
    #1;
    chk("done_single_pulse", 64'(o_build_done), 64'd0);

    dec(R1, 8'hFF, E1, 8'hFF);
    dec(R1, 8'h55, E1M, 8'h55);

    // Rebuild with decodes and a second start pulse injected mid-build.
    do_build(0, 1'b1, 0, lat);
    chk("rebuild_latency", 64'(lat), 64'd258);
    dec(R1, 8'hFF, E1, 8'hFF);

    // Non-bijective responder.
    do_build(2, 1'b0, 0, lat);
    chk("dup_build_latency", 64'(lat), 64'd258);
`ifdef ALIB_RANK_SYMBOL_DECODER_DUP_CHECK_EN
    chk("dup_err_at_done", 64'(o_table_error), 64'd1);
    @(posedge i_clk);
    #1;
    chk("dup_err_sticky", 64'(o_table_error), 64'd1);
`else
    chk("dup_err_disabled", 64'(o_table_error), 64'd0);
`endif

    // Reset in the middle of an identity build discards the table.
    do_build(1, 1'b0, 100, lat);
    dec(RID, 8'hFF, 64'd0, 8'h00);

    // Fresh identity build.
    do_build(1, 1'b0, 0, lat);
    chk("ident_latency", 64'(lat), 64'd258);
    chk("ident_error", 64'(o_table_error), 64'd0);
    dec(RID, 8'hFF, RID, 8'hFF);
    dec(RID, 8'h01, 64'h41, 8'h01);

    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
